// File: rtl/cache_pkg.sv
// Shared cache types: line-mover FSM states, line geometry and line type.
// Imported by the line mover and by the cache data array.
package cache_pkg;

  localparam int WORD_W           = 32;
  localparam int LINE_WORDS       = 4;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_WORDS) + 2;

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } mover_state_t;

endpackage

// File: rtl/cache_line_mover.sv
// Moves whole cache lines between cache and data memory, one word per cycle.
// Ports: req_* handshake + addrs/lines from the controller, done pulse, mem_* port.
module cache_line_mover
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_fill,
  input  logic                               req_evict,
  input  logic [DATA_WIDTH-1:0]              fill_addr,
  input  logic [DATA_WIDTH-1:0]              evict_addr,
  input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] wline,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] rline,
  output logic                               done,
  output logic                               mem_we,
  output logic [DATA_WIDTH-1:0]              mem_a,
  output logic [DATA_WIDTH-1:0]              mem_wd,
  output logic                               mem_byteaddr,
  input  logic [DATA_WIDTH-1:0]              mem_rd
);

  localparam int CW  = $clog2(WORDS_PER_LINE);
  localparam int OFF = CW + 2;

  mover_state_t state;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] ebase;
  logic [DATA_WIDTH-1:0] fbase;
  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] wl_q;
  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] rl_q;
  logic do_fill;
  logic do_evict;

  logic last;
  logic accept;
  logic [DATA_WIDTH-1:0] offs;
  logic unused_low;

  assign last   = &cnt;
  assign accept = req_valid && (state == IDLE)
               && (req_fill || req_evict);
  assign offs   = DATA_WIDTH'({cnt, 2'b00});

  // Line-offset bits of the request addresses are dropped on purpose.
  assign unused_low = ^{fill_addr[OFF-1:0],
                        evict_addr[OFF-1:0], do_evict};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ebase    <= '0;
      fbase    <= '0;
      wl_q     <= '0;
      rl_q     <= '0;
      do_fill  <= 1'b0;
      do_evict <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            ebase    <= {evict_addr[DATA_WIDTH-1:OFF], {OFF{1'b0}}};
            fbase    <= {fill_addr[DATA_WIDTH-1:OFF], {OFF{1'b0}}};
            wl_q     <= wline;
            do_fill  <= req_fill;
            do_evict <= req_evict;
            cnt      <= '0;
            state    <= req_evict ? EVICT : FILL;
          end
        end
        EVICT: begin
          cnt <= cnt + CW'(1);
          if (last) begin
            cnt   <= '0;
            state <= do_fill ? FILL : DONE;
          end
        end
        FILL: begin
          rl_q[cnt] <= mem_rd;
          cnt       <= cnt + CW'(1);
          if (last) begin
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port outputs depend on registered state only.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    unique case (state)
      EVICT: begin
        mem_we = 1'b1;
        mem_a  = ebase + offs;
        mem_wd = wl_q[cnt];
      end
      FILL:    mem_a = fbase + offs;
      default: ;
    endcase
  end

  assign mem_byteaddr = 1'b0;
  assign done         = (state == DONE);
  assign req_ready    = (state == IDLE);
  assign rline        = rl_q;

endmodule
